// File: rtl/fwd_hazard_unit_pkg.sv
// ----------------------------------------------------------------------------
// otter_hazard_pkg
// Shared types for the OTTER forwarding / load-use hazard unit.
//   fwd_sel_t : encoding of the EX-stage operand mux selects
//   shadow_t  : per-stage destination-register shadow {valid, rd, regwrite, is_load}
//   BUBBLE    : the shadow value of an empty pipeline slot
//   is_fwd()  : true for the selects that bypass the register file (1..4)
// ----------------------------------------------------------------------------
package otter_hazard_pkg;

  // Register-address width used by the shadow records.
  localparam int REG_AW = 5;

  typedef enum logic [2:0] {
    FWD_RF        = 3'd0,
    FWD_EXMEM_ALU = 3'd1,
    FWD_MEMWB_ALU = 3'd2,
    FWD_MEMWB_LD  = 3'd3,
    FWD_WB_HOLD   = 3'd4,
    FWD_ZERO      = 3'd5
  } fwd_sel_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              is_load;
  } shadow_t;

  localparam shadow_t BUBBLE = '{valid: 1'b0, rd: '0, regwrite: 1'b0, is_load: 1'b0};

  function automatic logic is_fwd(input fwd_sel_t sel);
    return (sel == FWD_EXMEM_ALU) || (sel == FWD_MEMWB_ALU) ||
           (sel == FWD_MEMWB_LD)  || (sel == FWD_WB_HOLD);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ----------------------------------------------------------------------------
// fwd_hazard_unit_if
// Decode-side bundle between the OTTER pipeline and the hazard unit.
//   master : pipeline side, drives id_* and flush, receives stall / selects
//   slave  : hazard unit side
// Optional HAZ_STATS_EN adds the stat_stalls / stat_fwds counters.
// ----------------------------------------------------------------------------
interface fwd_hazard_unit_if #(
  parameter int NREG_BITS = 5,
  parameter int SEL_W     = 3
) ();

  logic                 id_valid;
  logic [NREG_BITS-1:0] id_rs1;
  logic [NREG_BITS-1:0] id_rs2;
  logic                 id_rs1_used;
  logic                 id_rs2_used;
  logic [NREG_BITS-1:0] id_rd;
  logic                 id_regwrite;
  logic                 id_is_load;
  logic                 flush;
  logic                 stall;
  logic [SEL_W-1:0]     fwd_sel_a;
  logic [SEL_W-1:0]     fwd_sel_b;
`ifdef HAZ_STATS_EN
  logic [31:0]          stat_stalls;
  logic [31:0]          stat_fwds;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_regwrite, id_is_load, flush,
    input  stall, fwd_sel_a, fwd_sel_b, stat_stalls, stat_fwds
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_regwrite, id_is_load, flush,
    output stall, fwd_sel_a, fwd_sel_b, stat_stalls, stat_fwds
  );
`else
  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_regwrite, id_is_load, flush,
    input  stall, fwd_sel_a, fwd_sel_b
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_regwrite, id_is_load, flush,
    output stall, fwd_sel_a, fwd_sel_b
  );
`endif

endinterface

// File: rtl/fwd_hazard_unit_fwd_sel_calc.sv
// ----------------------------------------------------------------------------
// fwd_sel_calc
// Combinational operand-select for one decode source register.
//   s, used      : source address and whether the instruction reads it
//   ex, mem, wb  : destination shadows of the younger-to-older stages
//   sel          : operand mux select; the youngest qualifying producer wins
// ----------------------------------------------------------------------------
module fwd_sel_calc
  import otter_hazard_pkg::*;
#(
  parameter int NREG_BITS = REG_AW
) (
  input  logic [NREG_BITS-1:0] s,
  input  logic                 used,
  input  shadow_t              ex,
  input  shadow_t              mem,
  input  shadow_t              wb,
  output fwd_sel_t             sel
);

  function automatic logic produces(input shadow_t st, input logic [NREG_BITS-1:0] src);
    return st.valid && st.regwrite && (st.rd != '0) && (st.rd == src);
  endfunction

  always_comb begin
    // NOTE: default assignment first so every path drives sel and no latch is inferred.
    sel = FWD_RF;
    if (s == '0) begin
      sel = FWD_ZERO;               // x0 always reads as zero, never forwarded
    end else if (!used) begin
      sel = FWD_RF;
    end else if (produces(ex, s)) begin
      sel = FWD_EXMEM_ALU;
    end else if (produces(mem, s)) begin
      sel = mem.is_load ? FWD_MEMWB_LD : FWD_MEMWB_ALU;
    end else if (produces(wb, s)) begin
      sel = FWD_WB_HOLD;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// ----------------------------------------------------------------------------
// fwd_hazard_unit
// Forwarding and load-use hazard control for the 5-stage OTTER pipeline.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fwd_hazard_unit_if.slave
//     id_*          decode-stage instruction fields
//     flush         taken branch/jump in EX; kills ID/IF
//     stall         combinational load-use stall (hold PC and IF/ID)
//     fwd_sel_a/b   registered operand selects for the instruction in EX
// Optional macro HAZ_STATS_EN adds saturating stat_stalls / stat_fwds counters.
// ----------------------------------------------------------------------------
module fwd_hazard_unit
  import otter_hazard_pkg::*;
#(
  parameter int NREG_BITS = REG_AW,
  parameter int SEL_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  fwd_hazard_unit_if.slave  bus
);

  shadow_t  ex_q, mem_q, wb_q;
  fwd_sel_t sel_a_c, sel_b_c;
  fwd_sel_t sel_a_q, sel_b_q;
  logic     load_use;
  logic     stall;
  logic     kill;

  fwd_sel_calc #(.NREG_BITS(NREG_BITS)) u_calc_a (
    .s    (bus.id_rs1),
    .used (bus.id_rs1_used),
    .ex   (ex_q),
    .mem  (mem_q),
    .wb   (wb_q),
    .sel  (sel_a_c)
  );

  fwd_sel_calc #(.NREG_BITS(NREG_BITS)) u_calc_b (
    .s    (bus.id_rs2),
    .used (bus.id_rs2_used),
    .ex   (ex_q),
    .mem  (mem_q),
    .wb   (wb_q),
    .sel  (sel_b_c)
  );

  // A load in EX cannot forward its data until it reaches MEM/WB, so a
  // dependent decode instruction waits exactly one cycle.
  always_comb begin
    load_use = bus.id_valid && ex_q.valid && ex_q.is_load && ex_q.regwrite &&
               (ex_q.rd != '0) &&
               ((bus.id_rs1_used && (bus.id_rs1 == ex_q.rd)) ||
                (bus.id_rs2_used && (bus.id_rs2 == ex_q.rd)));
  end

  assign stall = load_use && !bus.flush;     // the flushed consumer is gone anyway
  assign kill  = stall || bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q    <= BUBBLE;
      mem_q   <= BUBBLE;
      wb_q    <= BUBBLE;
      sel_a_q <= FWD_RF;
      sel_b_q <= FWD_RF;
    end else begin
      // NOTE: non-blocking assignments make this a true shift: mem takes the
      // old ex and wb the old mem, independent of statement order.
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (kill || !bus.id_valid) begin
        ex_q <= BUBBLE;
      end else begin
        ex_q <= '{valid: 1'b1, rd: bus.id_rd, regwrite: bus.id_regwrite,
                  is_load: bus.id_is_load};
      end
      // Selects enter EX together with their instruction; a bubble reads RF.
      sel_a_q <= kill ? FWD_RF : sel_a_c;
      sel_b_q <= kill ? FWD_RF : sel_b_c;
    end
  end

  assign bus.stall     = stall;
  assign bus.fwd_sel_a = SEL_W'(sel_a_q);
  assign bus.fwd_sel_b = SEL_W'(sel_b_q);

`ifdef HAZ_STATS_EN
  logic [31:0] stat_stalls_q, stat_fwds_q;
  logic        fwd_seen;

  assign fwd_seen = is_fwd(sel_a_c) || is_fwd(sel_b_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_stalls_q <= '0;
      stat_fwds_q   <= '0;
    end else begin
      if (stall && (stat_stalls_q != '1)) begin
        stat_stalls_q <= stat_stalls_q + 32'd1;
      end
      if (!kill && fwd_seen && (stat_fwds_q != '1)) begin
        stat_fwds_q <= stat_fwds_q + 32'd1;
      end
    end
  end

  assign bus.stat_stalls = stat_stalls_q;
  assign bus.stat_fwds   = stat_fwds_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ----------------------------------------------------------------------------
// tb_fwd_hazard_unit
// Self-checking bench for fwd_hazard_unit. Expected selects are queued when an
// instruction is presented in ID and compared once it has entered EX.
// ----------------------------------------------------------------------------
module tb_fwd_hazard_unit;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] rd;
    logic       regwrite;
    logic       is_load;
  } instr_t;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   n_cmp;
  int   n_bad;

  fwd_hazard_unit_if #(.NREG_BITS(5), .SEL_W(3)) bus ();

  fwd_hazard_unit #(.NREG_BITS(5), .SEL_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction builders ----------------
  function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    return '{valid: 1'b1, rs1: a, rs2: b, rs1_used: 1'b1, rs2_used: 1'b1,
             rd: rd, regwrite: 1'b1, is_load: 1'b0};
  endfunction

  // rs2 is parked on x31 (never written) so the unused field yields select 0.
  function automatic instr_t ld(input logic [4:0] rd, input logic [4:0] a);
    return '{valid: 1'b1, rs1: a, rs2: 5'd31, rs1_used: 1'b1, rs2_used: 1'b0,
             rd: rd, regwrite: 1'b1, is_load: 1'b1};
  endfunction

  function automatic instr_t st(input logic [4:0] a, input logic [4:0] b);
    return '{valid: 1'b1, rs1: a, rs2: b, rs1_used: 1'b1, rs2_used: 1'b1,
             rd: 5'd0, regwrite: 1'b0, is_load: 1'b0};
  endfunction

  function automatic instr_t nop();
    return '{valid: 1'b0, rs1: 5'd31, rs2: 5'd31, rs1_used: 1'b0, rs2_used: 1'b0,
             rd: 5'd0, regwrite: 1'b0, is_load: 1'b0};
  endfunction

  task automatic drive(input instr_t i, input logic fl);
    bus.id_valid    = i.valid;
    bus.id_rs1      = i.rs1;
    bus.id_rs2      = i.rs2;
    bus.id_rs1_used = i.rs1_used;
    bus.id_rs2_used = i.rs2_used;
    bus.id_rd       = i.rd;
    bus.id_regwrite = i.regwrite;
    bus.id_is_load  = i.is_load;
    bus.flush       = fl;
  endtask

  // Present one instruction in ID for one cycle, check stall mid-cycle, then
  // check the selects registered for EX just after the clock edge.
  task automatic step(input instr_t i, input logic fl, input logic es,
                      input logic [2:0] ea, input logic [2:0] eb,
                      input bit chk, input string nm);
    exp_t e;
    @(negedge clk);
    drive(i, fl);
    #1;
    n_cmp++;
    if (bus.stall !== es) begin
      n_bad++;
      $display("FAIL %s stall: got %b want %b", nm, bus.stall, es);
    end
    if (chk) sb.push_back('{a: ea, b: eb});
    @(posedge clk);
    #1;
    if (chk) begin
      e = sb.pop_front();
      n_cmp++;
      if (bus.fwd_sel_a !== e.a) begin
        n_bad++;
        $display("FAIL %s fwd_sel_a: got %0d want %0d", nm, bus.fwd_sel_a, e.a);
      end
      n_cmp++;
      if (bus.fwd_sel_b !== e.b) begin
        n_bad++;
        $display("FAIL %s fwd_sel_b: got %0d want %0d", nm, bus.fwd_sel_b, e.b);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(nop(), 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(alu(5'd8, 5'd7, 5'd1), 1'b0);
    #1;
    n_cmp++;
    if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL reset stall: got %b want 0", bus.stall); end
    n_cmp++;
    if (bus.fwd_sel_a !== 3'd0) begin n_bad++; $display("FAIL reset sel_a: got %0d want 0", bus.fwd_sel_a); end
    n_cmp++;
    if (bus.fwd_sel_b !== 3'd0) begin n_bad++; $display("FAIL reset sel_b: got %0d want 0", bus.fwd_sel_b); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_ex_fwd();
    do_reset();
    step(alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "exf_w");
    step(alu(5'd6, 5'd5, 5'd5), 1'b0, 1'b0, 3'd1, 3'd1, 1'b1, "exf_r");
    step(alu(5'd14, 5'd1, 5'd2), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "young_w1");
    step(alu(5'd14, 5'd1, 5'd2), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "young_w2");
    step(alu(5'd15, 5'd14, 5'd14), 1'b0, 1'b0, 3'd1, 3'd1, 1'b1, "young_r");
  endtask

  task automatic test_load_use();
    do_reset();
    step(ld(5'd7, 5'd2), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "lu_ld");
    step(alu(5'd8, 5'd7, 5'd1), 1'b0, 1'b1, 3'd0, 3'd0, 1'b1, "lu_stall");
    step(alu(5'd8, 5'd7, 5'd1), 1'b0, 1'b0, 3'd3, 3'd0, 1'b1, "lu_use");
  endtask

  task automatic test_back_to_back();
    do_reset();
    step(ld(5'd7, 5'd2), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "bb_ld1");
    step(ld(5'd7, 5'd7), 1'b0, 1'b1, 3'd0, 3'd0, 1'b1, "bb_ld2_stall");
    step(ld(5'd7, 5'd7), 1'b0, 1'b0, 3'd3, 3'd0, 1'b1, "bb_ld2");
    step(alu(5'd10, 5'd7, 5'd7), 1'b0, 1'b1, 3'd0, 3'd0, 1'b1, "bb_use_stall");
    step(alu(5'd10, 5'd7, 5'd7), 1'b0, 1'b0, 3'd3, 3'd3, 1'b1, "bb_use");
    // Stores: only a store that reads the load's rd waits.
    step(ld(5'd7, 5'd2), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "st_ld1");
    step(st(5'd1, 5'd3), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "st_free");
    step(ld(5'd7, 5'd2), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "st_ld2");
    step(st(5'd7, 5'd3), 1'b0, 1'b1, 3'd0, 3'd0, 1'b1, "st_dep_stall");
    step(st(5'd7, 5'd3), 1'b0, 1'b0, 3'd3, 3'd0, 1'b1, "st_dep");
  endtask

  task automatic test_wb_hold();
    do_reset();
    step(alu(5'd9, 5'd1, 5'd2), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "mem_w");
    step(alu(5'd10, 5'd1, 5'd2), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "mem_u");
    step(alu(5'd12, 5'd1, 5'd9), 1'b0, 1'b0, 3'd0, 3'd2, 1'b1, "mem_r");
    step(alu(5'd9, 5'd1, 5'd2), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "wb_w");
    step(alu(5'd10, 5'd1, 5'd2), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "wb_u1");
    step(alu(5'd11, 5'd1, 5'd2), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "wb_u2");
    step(alu(5'd12, 5'd9, 5'd3), 1'b0, 1'b0, 3'd4, 3'd0, 1'b1, "wb_r");
    step(alu(5'd9, 5'd1, 5'd2), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "old_w");
    step(alu(5'd10, 5'd1, 5'd2), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "old_u1");
    step(alu(5'd11, 5'd1, 5'd2), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "old_u2");
    step(alu(5'd13, 5'd1, 5'd2), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "old_u3");
    step(alu(5'd12, 5'd9, 5'd3), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "old_r");
  endtask

  task automatic test_x0();
    do_reset();
    step(alu(5'd0, 5'd1, 5'd2), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "x0_w");
    step(alu(5'd13, 5'd0, 5'd0), 1'b0, 1'b0, 3'd5, 3'd5, 1'b1, "x0_r");
    step(ld(5'd0, 5'd1), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "x0_ld");
    step(alu(5'd14, 5'd0, 5'd3), 1'b0, 1'b0, 3'd5, 3'd0, 1'b1, "x0_ld_r");
  endtask

  task automatic test_invalid();
    instr_t ghost;
    do_reset();
    ghost = alu(5'd20, 5'd7, 5'd7);
    ghost.valid = 1'b0;
    step(ld(5'd7, 5'd2), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "inv_ld");
    step(ghost, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, "inv_nostall");
    step(alu(5'd8, 5'd7, 5'd1), 1'b0, 1'b0, 3'd3, 3'd0, 1'b1, "inv_after");
  endtask

  task automatic test_flush();
    do_reset();
    step(ld(5'd7, 5'd2), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "fl_ld");
    step(alu(5'd8, 5'd7, 5'd1), 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, "fl_lu");
    step(alu(5'd16, 5'd8, 5'd1), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "fl_bubble");
    step(alu(5'd5, 5'd1, 5'd2), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "fl_w");
    step(alu(5'd6, 5'd5, 5'd5), 1'b1, 1'b0, 3'd0, 3'd0, 1'b1, "fl_fwd");
  endtask

  task automatic test_mid_reset();
    do_reset();
    step(alu(5'd2, 5'd1, 5'd1), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "mr_w");
    step(ld(5'd7, 5'd2), 1'b0, 1'b0, 3'd1, 3'd0, 1'b1, "mr_ld");
    @(negedge clk);
    drive(alu(5'd8, 5'd7, 5'd1), 1'b0);
    #1;
    n_cmp++;
    if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL mr_pre stall: got %b want 1", bus.stall); end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL mr_async stall: got %b want 0", bus.stall); end
    n_cmp++;
    if (bus.fwd_sel_a !== 3'd0) begin n_bad++; $display("FAIL mr_async sel_a: got %0d want 0", bus.fwd_sel_a); end
    n_cmp++;
    if (bus.fwd_sel_b !== 3'd0) begin n_bad++; $display("FAIL mr_async sel_b: got %0d want 0", bus.fwd_sel_b); end
    @(negedge clk);
    rst = 1'b0;
`ifdef HAZ_STATS_EN
    n_cmp++;
    if (bus.stat_stalls !== 32'd0) begin n_bad++; $display("FAIL stat_stalls_rst: got %0d want 0", bus.stat_stalls); end
    n_cmp++;
    if (bus.stat_fwds !== 32'd0) begin n_bad++; $display("FAIL stat_fwds_rst: got %0d want 0", bus.stat_fwds); end
`endif
    step(alu(5'd8, 5'd7, 5'd1), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "mr_first");
    step(alu(5'd17, 5'd0, 5'd7), 1'b0, 1'b0, 3'd5, 3'd0, 1'b1, "mr_second");
`ifdef HAZ_STATS_EN
    step(ld(5'd7, 5'd2), 1'b0, 1'b0, 3'd0, 3'd0, 1'b1, "st_ld");
    step(alu(5'd8, 5'd7, 5'd1), 1'b0, 1'b1, 3'd0, 3'd0, 1'b1, "st_stall");
    step(alu(5'd8, 5'd7, 5'd1), 1'b0, 1'b0, 3'd3, 3'd0, 1'b1, "st_use");
    n_cmp++;
    if (bus.stat_stalls !== 32'd1) begin n_bad++; $display("FAIL stat_stalls: got %0d want 1", bus.stat_stalls); end
    n_cmp++;
    if (bus.stat_fwds !== 32'd1) begin n_bad++; $display("FAIL stat_fwds: got %0d want 1", bus.stat_fwds); end
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    drive(nop(), 1'b0);
    test_reset();
    test_ex_fwd();
    test_load_use();
    test_back_to_back();
    test_wb_hold();
    test_x0();
    test_invalid();
    test_flush();
    test_mid_reset();
    @(negedge clk);
    drive(nop(), 1'b0);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Forwarding and load-use hazard control for the 5-stage OTTER pipeline.
- Keeps a shadow of destination-register info for the EX, MEM and WB stages.
- Produces registered 3-bit operand selects that drive the two 6-to-1 operand muxes in EX.
- Raises a one-cycle stall with bubble insertion on load-use hazards, and honours branch flushes.

Parameters:
- NREG_BITS, 5, register-address width.
- SEL_W, 3, width of each operand select (must match the operand mux).

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- id_valid  in  1  decode stage holds a real instruction
- id_rs1  in  NREG_BITS  decode source 1 address
- id_rs2  in  NREG_BITS  decode source 2 address
- id_rs1_used  in  1  instruction reads rs1
- id_rs2_used  in  1  instruction reads rs2
- id_rd  in  NREG_BITS  decode destination
- id_regwrite  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- flush  in  1  branch/jump taken in EX; kill the ID and IF instructions
- stall  out  1  hold PC and IF/ID, insert bubble into EX (combinational)
- fwd_sel_a  out  SEL_W  operand A select for the EX instruction (registered)
- fwd_sel_b  out  SEL_W  operand B select for the EX instruction (registered)

Behaviour:
- Select encoding:
  - 0 = register file
  - 1 = EX/MEM ALU result
  - 2 = MEM/WB ALU result
  - 3 = MEM/WB load data
  - 4 = WB-stage retained writeback value
  - 5 = constant zero
  - 6 and 7 are never driven.
- Shadow stages ex_*, mem_*, wb_*: each holds {valid, rd, regwrite, is_load}.
- Shadow update every clock:
  - wb <= mem; mem <= ex.
  - ex <= bubble when stall or flush; otherwise ex <= ID fields.
  - A bubble has valid=0 and regwrite=0.
- Producer qualification: a stage matches source s only when valid && regwrite && rd != 0 && rd == s.
- Select computation in ID for each source s (rs1 gives sel_a, rs2 gives sel_b):
  - s == 0 or source unused -> 5 if s == 0, else 0.
  - ex matches -> 1.
  - else mem matches -> 3 if mem.is_load, else 2.
  - else wb matches -> 4.
  - else -> 0.
- Youngest producer always wins.
- The computed select is registered into fwd_sel_* on the same edge the instruction enters EX, so the value is valid for that whole EX cycle.
- On a stall or flush cycle, fwd_sel_* loads 0 (matching the bubble).
- stall = id_valid && ex.valid && ex.is_load && ex.regwrite && ex.rd != 0 && ((id_rs1_used && id_rs1 == ex.rd) || (id_rs2_used && id_rs2 == ex.rd)).
- Stall latency: exactly one cycle per load-use. On the next cycle the load is in mem and the consumer gets select 3.
- flush has priority over stall: when flush is asserted, stall is forced to 0 and a bubble enters EX.
- Reset (async, RST high):
  - All shadow valid/regwrite/is_load clear.
  - rd fields = 0.
  - fwd_sel_a = fwd_sel_b = 0; stall = 0.
- Reset mid-operation discards all hazard state. The first instruction after reset sees select 0 or 5 only.
- Back-to-back loads to the same rd: each stalls its dependent independently.
- No stall occurs on a store or branch unless it reads the load's rd.
- id_valid = 0 never stalls, and loads a bubble into ex.

Optional Feature:
- Macro: HAZ_STATS_EN.
- When defined:
  - Adds output stat_stalls (32) and output stat_fwds (32).
  - Both are saturating counters, cleared by RST.
  - stat_stalls increments on every cycle with stall = 1.
  - stat_fwds increments on every non-stall, non-flush cycle in which either computed select is in 1..4, by 1 per cycle.
- When undefined: the ports and counters are absent and the block behaves identically otherwise.

Decomposition:
- Shared package otter_hazard_pkg holds:
  - enum fwd_sel_t (FWD_RF=0, FWD_EXMEM_ALU=1, FWD_MEMWB_ALU=2, FWD_MEMWB_LD=3, FWD_WB_HOLD=4, FWD_ZERO=5).
  - struct shadow_t {valid, rd, regwrite, is_load}.
  - constant BUBBLE of type shadow_t.
- One sub-module, fwd_sel_calc: combinational per-source select from (s, used, ex, mem, wb). Instantiated twice, once per operand.

Test Plan:
- add x5 then add x6,x5,x5 -> no stall; fwd_sel_a = fwd_sel_b = 1 during the second add's EX cycle.
- lw x7 then add x8,x7,x1 -> stall = 1 for exactly one cycle; next EX has fwd_sel_a = 3, fwd_sel_b = 0.
- Writer to x9, two unrelated instructions, then a reader of x9 -> fwd_sel_a = 4; with three unrelated instructions in between -> 0.
- add x0,... then a reader of x0 -> fwd_sel = 5, never 1; lw x0 followed by a reader of x0 -> no stall.
- Load-use stall coincident with flush = 1 -> stall = 0, bubble in EX, fwd_sel = 0.
- RST asserted mid-stream while a load is in EX -> stall and selects drop to 0 asynchronously. With HAZ_STATS_EN, the counters read 0 after reset and stat_stalls = 1 after one load-use.
